// File: rtl/counter_credit_arbiter.sv
// Round-robin credit arbiter wrapped around a shared up/down occupancy counter.
// Requesters allocate credits and one release port hands credits back.
// At most one allocation is granted per cycle, and only when it still fits
// under MAX_VALUE after the release that happens in the same cycle.
module counter_credit_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int AMT_W      = 2,
  parameter int INIT_VALUE = 0,
  parameter int MAX_VALUE  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reinit,
  input  logic [WIDTH-1:0]         initial_value,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*AMT_W-1:0] req_amt,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     rel_valid,
  input  logic [AMT_W-1:0]         rel_amt,
  output logic [WIDTH-1:0]         value,
  output logic [WIDTH-1:0]         value_next,
  output logic                     busy,
  output logic                     underflow
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_ACTIVE, ST_REINIT} state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [WIDTH-1:0] r_value;
  logic             r_underflow;

  logic [AMT_W-1:0] w_amt_arr [NUM_REQ];
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_cand;
  logic             w_found;
  logic             w_load;
  logic             w_under;
  logic             w_grant;
  logic [WIDTH:0]   w_value_ext;
  logic [WIDTH:0]   w_rel_ext;
  logic [WIDTH:0]   w_after_rel;
  logic [WIDTH:0]   w_cand_amt;
  logic [WIDTH:0]   w_sum;

  // Split the flat amount bus into one entry per requester
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_amt
    assign w_amt_arr[g] = req_amt[g*AMT_W +: AMT_W];
  end

  // Find the first valid requester at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_cand  = w_idx;
      end
    end
  end

  // Release clamping, fit check for the candidate, grant and next counter value
  always_comb begin
    w_load      = reinit | (r_state == ST_REINIT);
    w_rel_ext   = rel_valid ? (WIDTH+1)'(rel_amt) : '0;
    w_value_ext = {1'b0, r_value};
    w_under     = (w_rel_ext > w_value_ext);
    w_after_rel = w_under ? '0 : (w_value_ext - w_rel_ext);
    w_cand_amt  = (WIDTH+1)'(w_amt_arr[w_cand]);
    w_sum       = w_after_rel + w_cand_amt;
    w_grant     = rst & ~w_load & w_found & (w_sum <= (WIDTH+1)'(MAX_VALUE));
    req_ready   = '0;
    if (w_grant) begin
      req_ready[w_cand] = 1'b1;
    end
    if (w_load) begin
      value_next = initial_value;
    end else if (w_grant) begin
      value_next = w_sum[WIDTH-1:0];
    end else begin
      value_next = w_after_rel[WIDTH-1:0];
    end
  end

  // State, counter, pointer and sticky underflow; reinit preempts grants and releases
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_ACTIVE;
      r_value     <= WIDTH'(INIT_VALUE);
      r_rr_ptr    <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_value <= value_next;
      r_state <= reinit ? ST_REINIT : ST_ACTIVE;
      if (w_grant) begin
        r_rr_ptr <= PTR_W'((int'(w_cand) + 1) % NUM_REQ);
      end
      if (!w_load && w_under) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign value     = r_value;
  assign busy      = (r_state == ST_REINIT);
  assign underflow = r_underflow;

endmodule

// File: tb/tb_counter_credit_arbiter.sv
// Bench for counter_credit_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_counter_credit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MAXV    = 15;
  localparam int INITV   = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       reinit;
  logic [3:0] initial_value;
  logic [3:0] req_valid;
  logic [7:0] req_amt;
  logic [3:0] req_ready;
  logic       rel_valid;
  logic [1:0] rel_amt;
  logic [3:0] value;
  logic [3:0] value_next;
  logic       busy;
  logic       underflow;

  int compared   = 0;
  int mismatched = 0;

  int mValue   = INITV;
  int mPtr     = 0;
  bit mReinit  = 1'b0;
  bit mUnder   = 1'b0;

  counter_credit_arbiter #(
    .NUM_REQ(4), .WIDTH(4), .AMT_W(2), .INIT_VALUE(INITV), .MAX_VALUE(MAXV)
  ) dut (
    .clk(clk), .rst(rst), .reinit(reinit), .initial_value(initial_value),
    .req_valid(req_valid), .req_amt(req_amt), .req_ready(req_ready),
    .rel_valid(rel_valid), .rel_amt(rel_amt), .value(value),
    .value_next(value_next), .busy(busy), .underflow(underflow)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Drive every input at once so each scenario line reads as one cycle of stimulus
  task automatic applyStimulus(input logic rstV, input logic reinitV, input logic [3:0] initV,
                               input logic [3:0] validV, input logic [7:0] amtV,
                               input logic relV, input logic [1:0] relAmtV);
    rst           = rstV;
    reinit        = reinitV;
    initial_value = initV;
    req_valid     = validV;
    req_amt       = amtV;
    rel_valid     = relV;
    rel_amt       = relAmtV;
  endtask

  // One comparison: count it, and report it when the DUT disagrees
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: derive this cycle's outputs from the rules, compare, then advance
  always @(negedge clk) begin
    int rel, base, cand, amt, expReady, expNext, idx;
    bit loading, grant;
    #2;
    if (!rst) begin
      mValue  = INITV;
      mPtr    = 0;
      mReinit = 1'b0;
      mUnder  = 1'b0;
    end
    rel     = rel_valid ? int'(rel_amt) : 0;
    loading = reinit || mReinit;
    base    = (rel > mValue) ? 0 : mValue - rel;
    cand    = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (mPtr + k) % NUM_REQ;
      if (cand < 0 && ((int'(req_valid) >> idx) & 1) == 1) cand = idx;
    end
    amt      = (cand >= 0) ? ((int'(req_amt) >> (2 * cand)) & 3) : 0;
    grant    = rst && !loading && cand >= 0 && (base + amt) <= MAXV;
    expReady = grant ? (1 << cand) : 0;
    expNext  = loading ? int'(initial_value) : (grant ? base + amt : base);

    checkOutput("model_value", 32'(value), 32'(mValue));
    checkOutput("model_busy", 32'(busy), 32'(mReinit));
    checkOutput("model_underflow", 32'(underflow), 32'(mUnder));
    checkOutput("model_req_ready", 32'(req_ready), 32'(expReady));
    if (rst) begin
      checkOutput("model_value_next", 32'(value_next), 32'(expNext));
      if (!loading && rel > mValue) mUnder = 1'b1;
      if (grant) mPtr = (cand + 1) % NUM_REQ;
      mValue  = expNext;
      mReinit = reinit;
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 4'hF, 8'h55, 0, 0);

    // Reset holds everything quiet even with all requesters asking
    @(negedge clk); #3;
    checkOutput("rst_value", 32'(value), 0);
    checkOutput("rst_ready", 32'(req_ready), 0);
    checkOutput("rst_underflow", 32'(underflow), 0);

    // Four requesters of amount 1 are served 0,1,2,3 in turn
    @(negedge clk);
    applyStimulus(1, 0, 0, 4'hF, 8'h55, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #3;
      checkOutput("rr_ready", 32'(req_ready), 32'(1 << k));
      checkOutput("rr_value", 32'(value), 32'(k));
      @(negedge clk);
    end

    // Reinit to 14, then an allocation of 3 does not fit until 2 is released alongside it
    applyStimulus(1, 1, 14, 4'h0, 8'h00, 0, 0);
    #3 checkOutput("reinit_next", 32'(value_next), 14);
    @(negedge clk);
    applyStimulus(1, 0, 14, 4'h0, 8'h00, 0, 0);
    #3 checkOutput("reinit_busy", 32'(busy), 1);
    checkOutput("reinit_value", 32'(value), 14);
    @(negedge clk);
    applyStimulus(1, 0, 14, 4'b0001, 8'h03, 0, 0);
    #3 checkOutput("nofit_ready", 32'(req_ready), 0);
    checkOutput("nofit_next", 32'(value_next), 14);
    @(negedge clk);
    applyStimulus(1, 0, 14, 4'b0001, 8'h03, 1, 2);
    #3 checkOutput("nofit_hold", 32'(value), 14);
    checkOutput("fit_ready", 32'(req_ready), 1);
    checkOutput("fit_next", 32'(value_next), 15);

    // Zero-amount grant to requester 1 moves the pointer to 2, then 3 and 0 win in turn
    @(negedge clk);
    applyStimulus(1, 0, 14, 4'b0010, 8'h00, 0, 0);
    #3 checkOutput("zero_amt_ready", 32'(req_ready), 2);
    checkOutput("full_value", 32'(value), 15);
    @(negedge clk);
    applyStimulus(1, 0, 14, 4'b1001, 8'b01000001, 1, 2);
    #3 checkOutput("wrap_ready3", 32'(req_ready), 8);
    checkOutput("wrap_next3", 32'(value_next), 14);
    @(negedge clk);
    #3 checkOutput("wrap_ready0", 32'(req_ready), 1);
    checkOutput("wrap_next0", 32'(value_next), 13);
    @(negedge clk);
    applyStimulus(1, 0, 14, 4'hF, 8'h00, 0, 0);
    #3 checkOutput("ptr_after_wrap", 32'(req_ready), 2);
    checkOutput("value_after_wrap", 32'(value), 13);

    // Drain to 1, then an oversize release clamps at 0 and latches underflow
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      applyStimulus(1, 0, 14, 4'h0, 8'h00, 1, 3);
    end
    @(negedge clk);
    #3 checkOutput("drain_value", 32'(value), 1);
    checkOutput("pre_underflow", 32'(underflow), 0);
    checkOutput("clamp_next", 32'(value_next), 0);
    @(negedge clk);
    applyStimulus(1, 0, 14, 4'h0, 8'h00, 0, 0);
    #3 checkOutput("clamp_value", 32'(value), 0);
    checkOutput("underflow_set", 32'(underflow), 1);

    // Reinit with a request and release in flight: nothing granted, value becomes 9
    @(negedge clk);
    applyStimulus(1, 1, 9, 4'b0001, 8'h01, 1, 1);
    #3 checkOutput("reinit_blocks_ready", 32'(req_ready), 0);
    checkOutput("reinit_first_busy", 32'(busy), 0);
    checkOutput("reinit_first_next", 32'(value_next), 9);
    @(negedge clk);
    applyStimulus(1, 0, 9, 4'b0001, 8'h01, 1, 1);
    #3 checkOutput("reinit2_busy", 32'(busy), 1);
    checkOutput("reinit2_value", 32'(value), 9);
    checkOutput("reinit2_ready", 32'(req_ready), 0);
    @(negedge clk);
    #3 checkOutput("active_busy", 32'(busy), 0);
    checkOutput("active_ready", 32'(req_ready), 1);
    checkOutput("underflow_sticky", 32'(underflow), 1);

    // Bring the value to 7, then pull reset mid-stream
    @(negedge clk);
    applyStimulus(1, 0, 9, 4'h0, 8'h00, 1, 2);
    #3 checkOutput("pre_rst_value", 32'(value), 9);
    @(negedge clk);
    checkOutput("mid_value", 32'(value), 7);
    applyStimulus(0, 0, 0, 4'hF, 8'h55, 0, 0);
    #3 checkOutput("async_rst_value", 32'(value), 0);
    checkOutput("async_rst_ready", 32'(req_ready), 0);
    checkOutput("async_rst_underflow", 32'(underflow), 0);
    @(negedge clk);
    applyStimulus(1, 0, 0, 4'hF, 8'h55, 0, 0);
    #3 checkOutput("post_rst_ptr", 32'(req_ready), 1);

    // Randomized traffic with occasional reinit and reset pulses
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      applyStimulus(($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 9) == 0),
                    4'($urandom), 4'($urandom), 8'($urandom),
                    1'($urandom), 2'($urandom));
    end

    @(negedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
